// File: rtl/alu_writeback_stage_pkg.sv
// Shared definitions for the ALU writeback stage: flag positions, branch codes, buffer states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_writeback_stage_pkg;

    // Bit positions inside the 4-bit {S,Z,C,V} flag vector.
    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Branch condition encodings; 100..110 are reserved and never taken.
    localparam logic [2:0] BR_BE     = 3'b000;
    localparam logic [2:0] BR_BLT    = 3'b001;
    localparam logic [2:0] BR_BLE    = 3'b010;
    localparam logic [2:0] BR_BNE    = 3'b011;
    localparam logic [2:0] BR_ALWAYS = 3'b111;

    // Occupancy of the 2-entry skid buffer.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Branch decision from a {S,Z,C,V} flag vector and a 3-bit condition code.
// Latency: purely combinational.
// Backpressure: none.
module branch_cond_eval
    import alu_writeback_stage_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [2:0] br_cond,
    output logic       taken
);

    logic s_xor_v;
    logic unused_carry;

    assign s_xor_v      = flags[FLAG_S] ^ flags[FLAG_V];
    // No supported condition looks at carry.
    assign unused_carry = flags[FLAG_C];

    // Decode the condition; reserved codes fall through to not-taken.
    always_comb begin
        taken = 1'b0;
        case (br_cond)
            BR_BE:     taken = flags[FLAG_Z];
            BR_BLT:    taken = s_xor_v;
            BR_BLE:    taken = flags[FLAG_Z] | s_xor_v;
            BR_BNE:    taken = ~flags[FLAG_Z];
            BR_ALWAYS: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU result capture into a 2-entry skid buffer feeding register writeback; owns CCR and branch eval.
// Latency: 1 cycle accept-to-out_valid; ccr visible 1 cycle after accept (FLAG_BYPASS_EN forwards in_flags to br_taken).
// Backpressure: in_ready = buffer not full (registered state only); head held stable while out_ready is low.
module alu_writeback_stage
    import alu_writeback_stage_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RD_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [3:0]        in_flags,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_we,
    input  logic              in_flag_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_we,
    input  logic              flush,
    output logic [3:0]        ccr,
    input  logic [2:0]        br_cond,
    output logic              br_taken
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [RD_W-1:0]   rd;
        logic              we;
    } entry_t;

    buf_state_t state, state_nxt;
    entry_t     head, tail, in_entry;
    logic       accept, pop;
    logic       load_head, load_tail, shift_tail;
    logic [3:0] br_flags;

    assign in_ready  = (state != BUF_TWO);
    assign out_valid = (state != BUF_EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign in_entry  = '{result: in_result, rd: in_rd, we: in_we};

    assign out_result = head.result;
    assign out_rd     = head.rd;
    assign out_we     = head.we;

    // Buffer occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BUF_EMPTY;
        else        state <= state_nxt;
    end

    // Next occupancy and which slot moves; flush overrides everything including a same-cycle accept.
    always_comb begin
        state_nxt  = state;
        load_head  = 1'b0;
        load_tail  = 1'b0;
        shift_tail = 1'b0;
        case (state)
            BUF_EMPTY: begin
                if (accept) begin
                    state_nxt = BUF_ONE;
                    load_head = 1'b1;
                end
            end
            BUF_ONE: begin
                if (accept && pop) begin
                    load_head = 1'b1;
                end else if (accept) begin
                    state_nxt = BUF_TWO;
                    load_tail = 1'b1;
                end else if (pop) begin
                    state_nxt = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (pop) begin
                    state_nxt  = BUF_ONE;
                    shift_tail = 1'b1;
                end
            end
            default: state_nxt = BUF_EMPTY;
        endcase
        if (flush) begin
            state_nxt  = BUF_EMPTY;
            load_head  = 1'b0;
            load_tail  = 1'b0;
            shift_tail = 1'b0;
        end
    end

    // Entry storage: head is written only on fill-from-empty, replace-on-pop or tail promotion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (load_head)       head <= in_entry;
            else if (shift_tail) head <= tail;
            if (load_tail)       tail <= in_entry;
        end
    end

    // CCR commits at accept regardless of flush: flags belong to an executed instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   ccr <= 4'b0000;
        else if (accept && in_flag_we) ccr <= in_flags;
    end

`ifdef FLAG_BYPASS_EN
    // Forward flags being committed this cycle so a following branch needs no bubble.
    assign br_flags = (accept && in_flag_we) ? in_flags : ccr;
`else
    assign br_flags = ccr;
`endif

    branch_cond_eval u_branch_cond_eval (
        .flags   (br_flags),
        .br_cond (br_cond),
        .taken   (br_taken)
    );

endmodule

// File: tb/tb_alu_writeback_stage.sv
module tb_alu_writeback_stage;

    localparam int DATA_W = 16;
    localparam int RD_W   = 3;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic [3:0]        in_flags;
    logic [RD_W-1:0]   in_rd;
    logic              in_we;
    logic              in_flag_we;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [RD_W-1:0]   out_rd;
    logic              out_we;
    logic              flush;
    logic [3:0]        ccr;
    logic [2:0]        br_cond;
    logic              br_taken;

    alu_writeback_stage #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_flags   (in_flags),
        .in_rd      (in_rd),
        .in_we      (in_we),
        .in_flag_we (in_flag_we),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_we     (out_we),
        .flush      (flush),
        .ccr        (ccr),
        .br_cond    (br_cond),
        .br_taken   (br_taken)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests;
    int fails;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [15:0] r, input logic [2:0] rd, input logic we,
                         input logic [3:0] f, input logic fwe);
        in_valid   = 1'b1;
        in_result  = r;
        in_rd      = rd;
        in_we      = we;
        in_flags   = f;
        in_flag_we = fwe;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_flag_we = 1'b0;
    endtask

    typedef struct {
        logic [3:0] flags;
        logic [2:0] cond;
        logic       exp;
    } br_vec_t;

    br_vec_t vecs[14];
    logic    exp_byp;

    initial begin
        tests = 0;
        fails = 0;

        vecs[0]  = '{4'b0100, 3'b000, 1'b1};
        vecs[1]  = '{4'b0100, 3'b011, 1'b0};
        vecs[2]  = '{4'b1000, 3'b001, 1'b1};
        vecs[3]  = '{4'b1000, 3'b010, 1'b1};
        vecs[4]  = '{4'b0000, 3'b000, 1'b0};
        vecs[5]  = '{4'b0000, 3'b011, 1'b1};
        vecs[6]  = '{4'b1001, 3'b001, 1'b0};
        vecs[7]  = '{4'b0001, 3'b010, 1'b1};
        vecs[8]  = '{4'b0100, 3'b010, 1'b1};
        vecs[9]  = '{4'b1111, 3'b111, 1'b1};
        vecs[10] = '{4'b1111, 3'b100, 1'b0};
        vecs[11] = '{4'b1111, 3'b101, 1'b0};
        vecs[12] = '{4'b1111, 3'b110, 1'b0};
        vecs[13] = '{4'b0000, 3'b111, 1'b1};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_result  = '0;
        in_flags   = '0;
        in_rd      = '0;
        in_we      = 1'b0;
        in_flag_we = 1'b0;
        out_ready  = 1'b0;
        flush      = 1'b0;
        br_cond    = 3'b000;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_we", out_we, 0);
        chk("rst_ccr", ccr, 0);
        chk("rst_in_ready", in_ready, 1);

        // Streaming: 1-cycle latency, in-order, in_ready never drops
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("stream_in_ready", in_ready, 1);
            offer(16'(i), 3'(i), 1'b1, 4'b0000, 1'b0);
            tick();
            chk("stream_out_valid", out_valid, 1);
            chk("stream_out_result", out_result, i);
            chk("stream_out_rd", out_rd, i & 7);
        end
        idle();
        tick();
        chk("stream_drained", out_valid, 0);

        // Backpressure: two accepts fill the buffer, third is held off
        out_ready = 1'b0;
        offer(16'h1234, 3'd1, 1'b1, 4'b0000, 1'b0);
        tick();
        chk("bp_ready_after1", in_ready, 1);
        chk("bp_head1", out_result, 16'h1234);
        offer(16'hABCD, 3'd2, 1'b0, 4'b0000, 1'b0);
        tick();
        chk("bp_ready_after2", in_ready, 0);
        offer(16'h5555, 3'd3, 1'b1, 4'b0000, 1'b0);
        tick();
        chk("bp_ready_held", in_ready, 0);
        chk("bp_head_stable", out_result, 16'h1234);
        chk("bp_head_rd_stable", out_rd, 1);
        out_ready = 1'b1;
        tick();
        chk("bp_pop1_result", out_result, 16'hABCD);
        chk("bp_pop1_we", out_we, 0);
        chk("bp_ready_after_pop", in_ready, 1);
        tick();
        chk("bp_third_result", out_result, 16'h5555);
        chk("bp_third_rd", out_rd, 3);
        idle();
        tick();
        chk("bp_drained", out_valid, 0);

        // CCR / branch table
        for (int i = 0; i < 14; i++) begin
            offer(16'h0, 3'd0, 1'b0, vecs[i].flags, 1'b1);
            br_cond = vecs[i].cond;
            tick();
            idle();
            #1;
            chk("tbl_ccr", ccr, vecs[i].flags);
            chk("tbl_br_taken", br_taken, vecs[i].exp);
        end

        // in_flag_we=0 leaves ccr untouched
        offer(16'h0, 3'd0, 1'b0, 4'b1111, 1'b0);
        tick();
        idle();
        chk("ccr_no_we", ccr, 4'b0000);

        // Compare-then-branch in the same cycle
`ifdef FLAG_BYPASS_EN
        exp_byp = 1'b1;
`else
        exp_byp = 1'b0;
`endif
        tick();
        br_cond = 3'b000;
        offer(16'h0, 3'd0, 1'b0, 4'b0100, 1'b1);
        #1;
        chk("bypass_same_cycle", br_taken, exp_byp);
        tick();
        idle();
        #1;
        chk("bypass_next_cycle", br_taken, 1);
        tick();

        // Flush with buffer full: offer is not accepted, so ccr is unchanged
        out_ready = 1'b0;
        offer(16'h0A0A, 3'd4, 1'b1, 4'b0000, 1'b0);
        tick();
        offer(16'h0B0B, 3'd5, 1'b1, 4'b0000, 1'b0);
        tick();
        chk("flush_full_ready", in_ready, 0);
        offer(16'h0C0C, 3'd6, 1'b1, 4'b1010, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        chk("flush_full_empty", out_valid, 0);
        chk("flush_full_ccr", ccr, 4'b0100);
        chk("flush_full_ready_back", in_ready, 1);

        // Flush with one entry plus a same-cycle accept: entry dropped, flags kept
        offer(16'h0D0D, 3'd1, 1'b1, 4'b0000, 1'b0);
        tick();
        offer(16'h0E0E, 3'd2, 1'b1, 4'b0110, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        chk("flush_acc_empty", out_valid, 0);
        chk("flush_acc_ccr", ccr, 4'b0110);
        out_ready = 1'b1;
        tick();
        chk("flush_acc_stays_empty", out_valid, 0);

        // Asynchronous reset mid-transfer
        out_ready = 1'b0;
        offer(16'h0F0F, 3'd7, 1'b1, 4'b1111, 1'b1);
        tick();
        chk("mid_pre_ccr", ccr, 4'b1111);
        chk("mid_pre_valid", out_valid, 1);
        offer(16'h1111, 3'd1, 1'b1, 4'b0001, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ccr", ccr, 0);
        chk("mid_rst_result", out_result, 0);
        idle();
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rel_ready", in_ready, 1);
        chk("mid_rel_valid", out_valid, 0);
        chk("mid_rel_ccr", ccr, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
